// File: rtl/ex_sched_pkg.sv
// ============================================================================
// Module      : ex_sched_pkg
// Description : Shared types and constants for the single-ALU EX scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_sched_pkg;

   localparam int         WIDTH_DEF = 64;
   localparam logic [3:0] ALU_ADD   = 4'b0010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      BR   = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/ex_alu_sched_if.sv
// ============================================================================
// Module      : ex_alu_sched_if
// Description : Bus to the external shared ALU (operands/control out, result in).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_alu_sched_if #(
   parameter int WIDTH = 64,
   parameter int CTL_W = 4
);
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [CTL_W-1:0] alu_ctl;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

   modport master (output alu_a, alu_b, alu_ctl, input alu_result, alu_zero);
   modport slave  (input alu_a, alu_b, alu_ctl, output alu_result, alu_zero);
endinterface

`default_nettype wire

// File: rtl/ex_alu_sched.sv
// ============================================================================
// Module      : ex_alu_sched
// Description : Time-shares one ALU between the EX main op and the branch-target
//               add. Optional macro EX_BACK2BACK_EN removes the RESP->IDLE bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_alu_sched
   import ex_sched_pkg::*;
#(
   parameter int               WIDTH   = WIDTH_DEF,
   parameter int               CTL_W   = 4,
   parameter logic [CTL_W-1:0] ADD_CTL = CTL_W'(ALU_ADD)
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             req_valid,
   output logic                  req_ready,
   input  wire logic             is_branch,
   input  wire logic             alu_src,
   input  wire logic [CTL_W-1:0] alu_control,
   input  wire logic [WIDTH-1:0] pc,
   input  wire logic [WIDTH-1:0] sign_imm,
   input  wire logic [WIDTH-1:0] read_data1,
   input  wire logic [WIDTH-1:0] read_data2,
   ex_alu_sched_if.master        alu,
   output logic                  rsp_valid,
   input  wire logic             rsp_ready,
   output logic [WIDTH-1:0]      alu_result_o,
   output logic                  zero_o,
   output logic [WIDTH-1:0]      pc_branch,
   output logic [WIDTH-1:0]      write_data,
   output logic                  stall
);

   state_t           r_state;
   logic             r_is_branch;
   logic             r_alu_src;
   logic [CTL_W-1:0] r_ctl;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_imm;
   logic [WIDTH-1:0] r_rd1;
   logic [WIDTH-1:0] r_rd2;
   logic             w_accept;

   always_comb begin
      req_ready = 1'b0;
      case (r_state)
         IDLE:    req_ready = 1'b1;
`ifdef EX_BACK2BACK_EN
         RESP:    req_ready = rsp_ready;
`else
         RESP:    req_ready = 1'b0;
`endif
         default: req_ready = 1'b0;
      endcase
      w_accept  = req_valid & req_ready;
      stall     = req_valid & ~req_ready;
      rsp_valid = (r_state == RESP);
   end

   // Operands come only from the latched copies so mid-op input changes are invisible.
   always_comb begin
      alu.alu_a   = '0;
      alu.alu_b   = '0;
      alu.alu_ctl = '0;
      case (r_state)
         OP: begin
            alu.alu_a   = r_rd1;
            alu.alu_b   = r_alu_src ? r_imm : r_rd2;
            alu.alu_ctl = r_ctl;
         end
         BR: begin
            alu.alu_a   = r_pc;
            alu.alu_b   = {r_imm[WIDTH-3:0], 2'b00};
            alu.alu_ctl = ADD_CTL;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_is_branch  <= 1'b0;
         r_alu_src    <= 1'b0;
         r_ctl        <= '0;
         r_pc         <= '0;
         r_imm        <= '0;
         r_rd1        <= '0;
         r_rd2        <= '0;
         alu_result_o <= '0;
         zero_o       <= 1'b0;
         pc_branch    <= '0;
         write_data   <= '0;
      end else begin
         if (w_accept) begin
            r_is_branch <= is_branch;
            r_alu_src   <= alu_src;
            r_ctl       <= alu_control;
            r_pc        <= pc;
            r_imm       <= sign_imm;
            r_rd1       <= read_data1;
            r_rd2       <= read_data2;
            write_data  <= read_data2;
         end
         case (r_state)
            IDLE: begin
               if (req_valid) r_state <= OP;
            end
            OP: begin
               alu_result_o <= alu.alu_result;
               zero_o       <= alu.alu_zero;
               if (r_is_branch) begin
                  r_state <= BR;
               end else begin
                  pc_branch <= '0;
                  r_state   <= RESP;
               end
            end
            BR: begin
               pc_branch <= alu.alu_result;
               r_state   <= RESP;
            end
            RESP: begin
               // A same-cycle accept only happens when back-to-back issue is enabled.
               if (rsp_ready) r_state <= w_accept ? OP : IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
